// File: rtl/counter_game_pkg.sv
// Shared definitions for the counter-game sequencer.
//   mode_e        : counting mode driven to the main counter on `control`
//   state_e       : sequencer FSM states
//   WIN_LIMIT_DEF : default tally value that ends a game
package counter_game_pkg;

   typedef enum logic [1:0] {
      UP1 = 2'b00,
      UP2 = 2'b01,
      DN1 = 2'b10,
      DN2 = 2'b11
   } mode_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      OVER = 2'd3
   } state_e;

   localparam int unsigned WIN_LIMIT_DEF = 15;

endpackage

// File: rtl/game_tally.sv
// Rising-edge detector feeding a saturating 4-bit tally.
//   clk, rst_n : clock, synchronous active-low reset
//   en         : count detected edges when high
//   clr        : clear the tally (wins over en)
//   flag       : level input whose 0->1 transitions are counted
//   count      : current tally, never exceeds LIMIT
//   hit        : high while count == LIMIT
module game_tally #(
   parameter logic [3:0] LIMIT = 4'd15
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic       clr,
   input  logic       flag,
   output logic [3:0] count,
   output logic       hit
);

   logic       prev_q, prev_d;
   logic [3:0] count_q, count_d;

   always_comb begin
      // Previous value tracks the flag every cycle, so a flag already high
      // when counting is enabled does not produce a spurious edge.
      prev_d  = flag;
      count_d = count_q;
      if (clr) begin
         count_d = 4'd0;
      end else if (en && flag && !prev_q && (count_q != LIMIT)) begin
         count_d = count_q + 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         prev_q  <= 1'b0;
         count_q <= 4'd0;
      end else begin
         prev_q  <= prev_d;
         count_q <= count_d;
      end
   end

   assign count = count_q;
   assign hit   = (count_q == LIMIT);

endmodule

// File: rtl/game_sequencer.sv
// Game sequencer: loads the main counter, tallies its winner/loser flags and
// declares a result once either tally reaches WIN_LIMIT.
//   clk, rst_n          : clock, synchronous active-low reset
//   start, seed, mode_req, mode_wr : game start / configuration inputs
//   winner, loser       : level flags from the main counter
//   init, initial_val, control     : load strobe, load value, mode to counter
//   win_count, lose_count          : per-game edge tallies
//   game_over, gamer, busy         : status; gamer=1 means winner side won
//
// state | meaning
// IDLE  | waiting for start after reset
// LOAD  | one cycle, init=1 loads the main counter
// RUN   | game in progress, flag edges are tallied
// OVER  | result held until the next start
module game_sequencer
   import counter_game_pkg::*;
#(
   parameter int unsigned WIN_LIMIT = WIN_LIMIT_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [3:0] seed,
   input  logic [1:0] mode_req,
   input  logic       mode_wr,
   input  logic       winner,
   input  logic       loser,
   output logic       init,
   output logic [3:0] initial_val,
   output logic [1:0] control,
   output logic [3:0] win_count,
   output logic [3:0] lose_count,
   output logic       game_over,
   output logic       gamer,
   output logic       busy
);

   localparam logic [3:0] LIMIT = 4'(WIN_LIMIT);

   state_e     state_q, state_d;
   logic       init_q, init_d;
   logic [3:0] initial_val_q, initial_val_d;
   logic [1:0] control_q, control_d;
   logic       game_over_q, game_over_d;
   logic       gamer_q, gamer_d;
   logic       busy_q, busy_d;

   logic       tally_clr;
   logic       tally_en;
   logic       win_hit, lose_hit;

   // Once a tally sits at the limit the result is decided; freezing both
   // tallies keeps the loser side from catching up in the exit cycle.
   assign tally_en = (state_q == RUN) && !(win_hit || lose_hit);

   always_comb begin
      state_d       = state_q;
      initial_val_d = initial_val_q;
      control_d     = control_q;
      gamer_d       = gamer_q;
      tally_clr     = 1'b0;
      case (state_q)
         IDLE, OVER: begin
            if (start) begin
               initial_val_d = seed;
               control_d     = mode_req;
               gamer_d       = 1'b0;
               tally_clr     = 1'b1;
               state_d       = LOAD;
            end
         end
         LOAD: state_d = RUN;
         RUN: begin
            if (mode_wr) begin
               control_d = mode_req;
            end
            if (win_hit || lose_hit) begin
               state_d = OVER;
               gamer_d = win_hit;
            end
         end
         default: state_d = IDLE;
      endcase
      // Status outputs are registered from the next state so they line up
      // with the state they describe.
      init_d      = (state_d == LOAD);
      busy_d      = (state_d == LOAD) || (state_d == RUN);
      game_over_d = (state_d == OVER);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         init_q        <= 1'b0;
         initial_val_q <= 4'd0;
         control_q     <= 2'd0;
         game_over_q   <= 1'b0;
         gamer_q       <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         init_q        <= init_d;
         initial_val_q <= initial_val_d;
         control_q     <= control_d;
         game_over_q   <= game_over_d;
         gamer_q       <= gamer_d;
         busy_q        <= busy_d;
      end
   end

   game_tally #(.LIMIT(LIMIT)) u_win_tally (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (tally_en),
      .clr   (tally_clr),
      .flag  (winner),
      .count (win_count),
      .hit   (win_hit)
   );

   game_tally #(.LIMIT(LIMIT)) u_lose_tally (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (tally_en),
      .clr   (tally_clr),
      .flag  (loser),
      .count (lose_count),
      .hit   (lose_hit)
   );

   assign init        = init_q;
   assign initial_val = initial_val_q;
   assign control     = control_q;
   assign game_over   = game_over_q;
   assign gamer       = gamer_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Scoreboard bench for game_sequencer: stimulus pushes cycle-stamped
// expected output vectors; a negedge monitor pops and compares them.
module tb_game_sequencer;
   import counter_game_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n, start, mode_wr, winner, loser;
   logic [3:0] seed;
   logic [1:0] mode_req;
   logic       init, game_over, gamer, busy;
   logic [3:0] initial_val, win_count, lose_count;
   logic [1:0] control;

   always #5 clk = ~clk;

   game_sequencer #(.WIN_LIMIT(15)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .seed        (seed),
      .mode_req    (mode_req),
      .mode_wr     (mode_wr),
      .winner      (winner),
      .loser       (loser),
      .init        (init),
      .initial_val (initial_val),
      .control     (control),
      .win_count   (win_count),
      .lose_count  (lose_count),
      .game_over   (game_over),
      .gamer       (gamer),
      .busy        (busy)
   );

   typedef struct {
      int          stamp;
      string       name;
      logic [17:0] v;
   } exp_t;

   exp_t sb[$];
   int   ncyc    = 0;
   int   n_tests = 0;
   int   n_fail  = 0;

   logic [3:0] m_iv, m_wc, m_lc;
   logic [1:0] m_ctrl;

   // {init, initial_val, control, win_count, lose_count, game_over, gamer, busy}
   function automatic logic [17:0] pack(logic ini, logic [3:0] iv, logic [1:0] ct,
                                        logic [3:0] wc, logic [3:0] lc,
                                        logic go, logic gm, logic bz);
      return {ini, iv, ct, wc, lc, go, gm, bz};
   endfunction

   // Expect the model state at the negedge following k more rising edges.
   task automatic expect_at(int k, string name, logic ini, logic go, logic gm, logic bz);
      exp_t e;
      e.stamp = ncyc + 1 + k;
      e.name  = name;
      e.v     = pack(ini, m_iv, m_ctrl, m_wc, m_lc, go, gm, bz);
      sb.push_back(e);
   endtask

   task automatic tick(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse(logic w, logic l, int len);
      winner = w;
      loser  = l;
      tick(len);
      winner = 1'b0;
      loser  = 1'b0;
      tick(1);
   endtask

   always @(negedge clk) begin : monitor
      logic [17:0] act;
      exp_t        e;
      ncyc = ncyc + 1;
      act  = pack(init, initial_val, control, win_count, lose_count, game_over, gamer, busy);
      while (sb.size() > 0 && sb[0].stamp <= ncyc) begin
         e = sb.pop_front();
         n_tests++;
         if (e.stamp != ncyc || act !== e.v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d, due %0d)",
                     e.name, act, e.v, ncyc, e.stamp);
         end
      end
   end

   initial begin
      rst_n = 1'b0; start = 1'b0; seed = 4'h0; mode_req = 2'b00;
      mode_wr = 1'b0; winner = 1'b0; loser = 1'b0;
      m_iv = 4'h0; m_ctrl = 2'b00; m_wc = 4'h0; m_lc = 4'h0;

      tick(2);
      expect_at(0, "reset_state", 0, 0, 0, 0);
      tick(1);
      rst_n = 1'b1;
      winner = 1'b1;
      tick(1);
      winner = 1'b0;
      expect_at(0, "idle_edge_ignored", 0, 0, 0, 0);
      tick(1);

      // start with seed 3, mode UP2
      expect_at(0, "idle_before_start", 0, 0, 0, 0);
      start = 1'b1; seed = 4'h3; mode_req = UP2;
      m_iv = 4'h3; m_ctrl = 2'b01;
      expect_at(1, "load_init", 1, 0, 0, 1);
      expect_at(2, "run_entry", 0, 0, 0, 1);
      tick(1);
      start = 1'b0; seed = 4'h0; mode_req = UP1;
      tick(2);

      // 3 winner pulses, loser pulse held 4 cycles, another loser pulse
      for (int i = 0; i < 3; i++) begin
         pulse(1'b1, 1'b0, 1);
         m_wc = m_wc + 4'd1;
         expect_at(0, "win_pulse", 0, 0, 0, 1);
      end
      loser = 1'b1;
      tick(1);
      m_lc = 4'd1;
      expect_at(0, "lose_held_first", 0, 0, 0, 1);
      tick(3);
      expect_at(0, "lose_held_once", 0, 0, 0, 1);
      loser = 1'b0;
      tick(1);
      pulse(1'b0, 1'b1, 1);
      m_lc = 4'd2;
      expect_at(0, "tally_3_2", 0, 0, 0, 1);

      // mid-game mode change
      mode_req = DN1; mode_wr = 1'b1;
      m_ctrl = 2'b10;
      expect_at(1, "mode_wr_run", 0, 0, 0, 1);
      tick(1);
      mode_wr = 1'b0; mode_req = UP1;
      tick(1);
      expect_at(0, "mode_held", 0, 0, 0, 1);

      // drive both tallies to 14, then a simultaneous edge
      pulse(1'b0, 1'b1, 1);
      m_lc = 4'd3;
      for (int i = 0; i < 11; i++) pulse(1'b1, 1'b1, 1);
      m_wc = 4'd14; m_lc = 4'd14;
      expect_at(0, "both_14", 0, 0, 0, 1);
      winner = 1'b1; loser = 1'b1;
      m_wc = 4'd15; m_lc = 4'd15;
      expect_at(1, "both_15", 0, 0, 0, 1);
      expect_at(2, "over_winner_priority", 0, 1, 1, 0);
      tick(1);
      winner = 1'b0; loser = 1'b0;
      tick(2);

      // edges and mode_wr in OVER are ignored; restart with seed A
      pulse(1'b1, 1'b0, 1);
      pulse(1'b1, 1'b1, 2);
      mode_req = DN2; mode_wr = 1'b1;
      tick(1);
      mode_wr = 1'b0;
      expect_at(0, "over_hold", 0, 1, 1, 0);
      start = 1'b1; seed = 4'hA; mode_req = UP1;
      m_iv = 4'hA; m_ctrl = 2'b00; m_wc = 4'd0; m_lc = 4'd0;
      expect_at(1, "restart_load", 1, 0, 0, 1);
      expect_at(2, "restart_run", 0, 0, 0, 1);
      tick(1);
      start = 1'b0;
      tick(2);

      // reset mid-RUN with a simultaneous start
      for (int i = 0; i < 7; i++) pulse(1'b0, 1'b1, 1);
      m_lc = 4'd7;
      expect_at(0, "lose_7", 0, 0, 0, 1);
      rst_n = 1'b0; start = 1'b1; seed = 4'hF; mode_req = DN2;
      m_iv = 4'h0; m_ctrl = 2'b00; m_wc = 4'd0; m_lc = 4'd0;
      expect_at(1, "mid_run_reset", 0, 0, 0, 0);
      tick(1);
      rst_n = 1'b1; start = 1'b0;
      expect_at(1, "start_in_reset_ignored", 0, 0, 0, 0);
      tick(1);

      // loser side wins a full game
      start = 1'b1; seed = 4'h5; mode_req = DN2;
      m_iv = 4'h5; m_ctrl = 2'b11;
      expect_at(1, "third_load", 1, 0, 0, 1);
      tick(1);
      start = 1'b0;
      tick(1);
      for (int i = 0; i < 15; i++) pulse(1'b0, 1'b1, 1);
      m_lc = 4'd15;
      expect_at(0, "loser_wins", 0, 1, 0, 0);
      pulse(1'b0, 1'b1, 1);
      expect_at(0, "over_saturated", 0, 1, 0, 0);

      for (int i = 0; i < 10 && sb.size() > 0; i++) tick(1);
      if (sb.size() > 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL scoreboard_drain: %0d pending, expected 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
